// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } mem_state_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = 2'b00;
  localparam fwd_sel_t FWD_W  = 2'b01;
  localparam fwd_sel_t FWD_M  = 2'b10;

  localparam logic [3:0] REG_PC = 4'hF;

  // Operand source for one E-stage register read; the newest producer (M) wins
  // over W, and the PC is always taken from the register file path.
  function automatic fwd_sel_t fwd_pick(
    input logic [3:0] ra,
    input logic [3:0] wa_m,
    input logic       rw_m,
    input logic [3:0] wa_w,
    input logic       rw_w
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (ra != REG_PC) begin
      if (rw_m && (ra == wa_m))
        sel = FWD_M;
      else if (rw_w && (ra == wa_w))
        sel = FWD_W;
    end
    return sel;
  endfunction

  // True when a D-stage source depends on an in-flight write that has not
  // reached the register file yet.
  function automatic logic raw_dep(
    input logic [3:0] ra,
    input logic [3:0] wa_e,
    input logic       rw_e,
    input logic [3:0] wa_m,
    input logic       rw_m
  );
    return (ra != REG_PC) && ((rw_e && (ra == wa_e)) || (rw_m && (ra == wa_m)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mem_wait_fsm.sv
// Memory-wait sequencer: holds the pipeline while a data-memory access is
// outstanding, abandons it after TIMEOUT_CYCLES wait cycles and raises a
// sticky timeout flag.
//
//   state | meaning
//   IDLE  | no access outstanding (a new un-acked request holds this cycle)
//   WAIT  | access outstanding, pipeline held, counting wait cycles
//   ERR   | access abandoned; M instruction retires as a bubble
module mem_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic MemReqM,
  input  logic MemAckM,
  output logic MemHold,
  output logic InErr,
  output logic MemTimeout
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  mem_state_t       state;
  mem_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             timeout_q;

  // next-state decode; an ack always beats the timeout limit
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (MemReqM && !MemAckM) state_nxt = WAIT;
      WAIT: begin
        if (MemAckM)
          state_nxt = IDLE;
        else if (cnt == CNT_LAST)
          state_nxt = ERR;
      end
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state, wait counter (held at zero outside WAIT, saturating) and sticky flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state != WAIT)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
      if (state_nxt == ERR)
        timeout_q <= 1'b1;
    end
  end

  assign MemHold    = !reset && ((((state == IDLE) && MemReqM) || (state == WAIT)) && !MemAckM);
  assign InErr      = !reset && (state == ERR);
  assign MemTimeout = !reset && timeout_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: operand
// forwarding selects, load-use / RAW stalls, branch flushes and the global
// hold while a data-memory access is outstanding.
// Build option: define HAZARD_FWD_EN to enable operand forwarding; without it
// the forwarding selects are tied to the register file and any RAW dependency
// on E or M stalls D.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemToRegE,
  input  logic       BranchTakenE,
  input  logic       PCSrcW,
  input  logic       MemReqM,
  input  logic       MemAckM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic       MemTimeout
);

  logic     mem_hold;
  logic     in_err;
  logic     data_stall;
  fwd_sel_t fwd_a;
  fwd_sel_t fwd_b;

  mem_wait_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_mem_wait (
    .clk       (clk),
    .reset     (reset),
    .MemReqM   (MemReqM),
    .MemAckM   (MemAckM),
    .MemHold   (mem_hold),
    .InErr     (in_err),
    .MemTimeout(MemTimeout)
  );

`ifdef HAZARD_FWD_EN
  assign fwd_a      = fwd_pick(RA1E, WA3M, RegWriteM, WA3W, RegWriteW);
  assign fwd_b      = fwd_pick(RA2E, WA3M, RegWriteM, WA3W, RegWriteW);
  // only a load in E cannot be covered by forwarding
  assign data_stall = MemToRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));
`else
  logic unused_fwd_inputs;

  assign fwd_a      = FWD_RF;
  assign fwd_b      = FWD_RF;
  // W is safe without a check: the register file writes on the falling edge
  assign data_stall = raw_dep(RA1D, WA3E, RegWriteE, WA3M, RegWriteM)
                    | raw_dep(RA2D, WA3E, RegWriteE, WA3M, RegWriteM);
  assign unused_fwd_inputs = ^{RA1E, RA2E, WA3W, RegWriteW, MemToRegE};
`endif

  assign ForwardAE = reset ? FWD_RF : fwd_a;
  assign ForwardBE = reset ? FWD_RF : fwd_b;

  // stall/flush steering: a memory hold freezes everything and defers branch
  // flushes until release; otherwise hazards and branches drive the controls
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!reset) begin
      if (mem_hold) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = data_stall;
        StallD = data_stall;
        FlushD = BranchTakenE | PCSrcW;
        FlushE = data_stall | BranchTakenE;
        FlushW = in_err;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios followed by random
// stimulus, checked against a cycle-level reference model of the rules.
module tb_pipe_hazard_ctrl;

  localparam int TO = 8;
`ifdef HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] RA1D = '0, RA2D = '0, RA1E = '0, RA2E = '0;
  logic [3:0] WA3E = '0, WA3M = '0, WA3W = '0;
  logic       RegWriteE = 1'b0, RegWriteM = 1'b0, RegWriteW = 1'b0;
  logic       MemToRegE = 1'b0, BranchTakenE = 1'b0, PCSrcW = 1'b0;
  logic       MemReqM = 1'b0, MemAckM = 1'b0;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;

  pipe_hazard_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .BranchTakenE(BranchTakenE), .PCSrcW(PCSrcW),
    .MemReqM(MemReqM), .MemAckM(MemAckM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemTimeout(MemTimeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic sf, sd, se, sm, fd, fe, fw, to;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model: is an access outstanding, how many wait cycles so far,
  // is this the abandoned-access bubble cycle, has a timeout ever happened
  bit m_wait = 0, m_err = 0, m_to = 0;
  int m_waited = 0;

  function automatic logic [1:0] ref_fwd(input logic [3:0] ra);
    logic [1:0] r;
    r = 2'b00;
    if (ra != 4'd15) begin
      if (RegWriteM && ra == WA3M) r = 2'b10;
      else if (RegWriteW && ra == WA3W) r = 2'b01;
    end
    return FWD_EN ? r : 2'b00;
  endfunction

  function automatic bit pending_write(input logic [3:0] ra);
    return (ra != 4'd15) && ((RegWriteE && ra == WA3E) || (RegWriteM && ra == WA3M));
  endfunction

  task automatic expect_cycle();
    exp_t e;
    bit   hold, ldr, raw, dstall;
    e = '0;
    if (!reset) begin
      hold   = (m_wait || (!m_err && MemReqM)) && !MemAckM;
      ldr    = MemToRegE && RegWriteE && (RA1D == WA3E || RA2D == WA3E);
      raw    = pending_write(RA1D) || pending_write(RA2D);
      dstall = FWD_EN ? ldr : raw;
      e.fa = ref_fwd(RA1E);
      e.fb = ref_fwd(RA2E);
      e.to = m_to;
      if (hold) begin
        e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.fw = 1;
      end else begin
        e.sf = dstall;
        e.sd = dstall;
        e.fd = BranchTakenE || PCSrcW;
        e.fe = dstall || BranchTakenE;
        e.fw = m_err;
      end
    end
    sb_q.push_back(e);
    if (reset) begin
      m_wait = 0; m_err = 0; m_to = 0; m_waited = 0;
    end else if (m_err) begin
      m_err = 0;
    end else if (m_wait) begin
      if (MemAckM) m_wait = 0;
      else begin
        m_waited++;
        if (m_waited >= TO) begin m_wait = 0; m_err = 1; m_to = 1; end
      end
    end else if (MemReqM && !MemAckM) begin
      m_wait = 1; m_waited = 0;
    end
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual %0d required %0d", name, $time, act, req);
    end
  endtask

  // monitor: compare the DUT against the oldest expectation mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("ForwardAE", ForwardAE, e.fa);
        chk("ForwardBE", ForwardBE, e.fb);
        chk("StallF", 2'(StallF), 2'(e.sf));
        chk("StallD", 2'(StallD), 2'(e.sd));
        chk("StallE", 2'(StallE), 2'(e.se));
        chk("StallM", 2'(StallM), 2'(e.sm));
        chk("FlushD", 2'(FlushD), 2'(e.fd));
        chk("FlushE", 2'(FlushE), 2'(e.fe));
        chk("FlushW", 2'(FlushW), 2'(e.fw));
        chk("MemTimeout", 2'(MemTimeout), 2'(e.to));
      end
    end
  end

  task automatic tick();
    expect_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    RA1D = '0; RA2D = '0; RA1E = '0; RA2E = '0;
    WA3E = '0; WA3M = '0; WA3W = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemToRegE = 0; BranchTakenE = 0; PCSrcW = 0;
    MemReqM = 0; MemAckM = 0;
  endtask

  function automatic logic [3:0] rreg();
    return ($urandom_range(0, 5) == 5) ? 4'hF : 4'($urandom_range(0, 3));
  endfunction

  task automatic rand_inputs();
    RA1D = rreg(); RA2D = rreg(); RA1E = rreg(); RA2E = rreg();
    WA3E = rreg(); WA3M = rreg(); WA3W = rreg();
    RegWriteE = 1'($urandom_range(0, 1));
    RegWriteM = 1'($urandom_range(0, 1));
    RegWriteW = 1'($urandom_range(0, 1));
    MemToRegE = 1'($urandom_range(0, 1));
    BranchTakenE = ($urandom_range(0, 3) == 0);
    PCSrcW = ($urandom_range(0, 5) == 0);
    MemReqM = 1'($urandom_range(0, 1));
    MemAckM = ($urandom_range(0, 4) == 0);
    reset = ($urandom_range(0, 149) == 0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // reset state
    tick();
    tick();
    reset = 0;
    clear_inputs();
    tick();
    // forwarding priority, W fallback, R15 never forwarded
    RA1E = 3; RA2E = 3; WA3M = 3; RegWriteM = 1; WA3W = 3; RegWriteW = 1;
    tick();
    RegWriteM = 0;
    tick();
    RA1E = 15; RA2E = 15; WA3M = 15; RegWriteM = 1; WA3W = 15;
    tick();
    clear_inputs();
    // load-use for one cycle
    MemToRegE = 1; RegWriteE = 1; WA3E = 5; RA2D = 5;
    tick();
    clear_inputs();
    tick();
    // memory wait, ack in the fifth cycle
    MemReqM = 1;
    repeat (4) tick();
    MemAckM = 1;
    tick();
    clear_inputs();
    tick();
    // ack with the request: no hold
    MemReqM = 1; MemAckM = 1;
    tick();
    clear_inputs();
    tick();
    // timeout, then sticky flag
    MemReqM = 1;
    repeat (11) tick();
    clear_inputs();
    repeat (3) tick();
    // branch during hold is deferred until release
    MemReqM = 1; BranchTakenE = 1;
    repeat (3) tick();
    MemAckM = 1;
    tick();
    MemReqM = 0; MemAckM = 0;
    tick();
    clear_inputs();
    tick();
    // ack on the limit cycle wins over the timeout (after a reset to clear the flag)
    reset = 1;
    tick();
    reset = 0;
    MemReqM = 1;
    repeat (TO) tick();
    MemAckM = 1;
    tick();
    clear_inputs();
    tick();
    // reset asserted mid-wait
    MemReqM = 1;
    repeat (3) tick();
    reset = 1;
    tick();
    reset = 0;
    clear_inputs();
    tick();
    WA3M = 7; RegWriteM = 1; RA1D = 7;
    tick();
    clear_inputs();
    tick();
    // load-use together with a taken branch
    MemToRegE = 1; RegWriteE = 1; WA3E = 2; RA1D = 2; BranchTakenE = 1;
    tick();
    clear_inputs();
    tick();
    // random traffic
    repeat (1500) begin
      rand_inputs();
      tick();
    end
    reset = 0;
    clear_inputs();
    tick();
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
